// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: sequences multi-cycle mult/div operations,
// owns the architectural HI/LO registers and raises the pipeline stall.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sign_q, sign_d;

  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

  // Sign-extending both operands to 64 bits makes the low 64 bits of an
  // unsigned multiply equal the two's-complement product.
  always_comb begin
    a_ext = {{32{sign_q & a_q[31]}}, a_q};
    b_ext = {{32{sign_q & b_q[31]}}, b_q};
    prod  = a_ext * b_ext;
  end

  // Divide on magnitudes so 0x80000000 / -1 needs no special case; the zero
  // divisor is replaced only to keep the divider defined, its result is dropped.
  always_comb begin
    a_neg   = sign_q & a_q[31];
    b_neg   = sign_q & b_q[31];
    a_mag   = a_neg ? (32'd0 - a_q) : a_q;
    b_mag   = b_neg ? (32'd0 - b_q) : b_q;
    divisor = (b_q == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d = MUL;
              cnt_d   = 4'(MUL_CYCLES - 1);
              busy_d  = 1'b1;
              a_d     = rs_val;
              b_d     = rt_val;
              sign_d  = ~op[0];
            end
            OP_DIV, OP_DIVU: begin
              state_d = DIV;
              cnt_d   = 4'(DIV_CYCLES - 1);
              busy_d  = 1'b1;
              a_d     = rs_val;
              b_d     = rt_val;
              sign_d  = ~op[0];
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DIV: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
    end
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = md_use & (busy_q | (start & (op[2:1] == 2'b00 || op[2:1] == 2'b01)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed results.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        md_use;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .md_use(md_use),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    start = 1'b0; op = 3'b000; rs_val = 32'd0; rt_val = 32'd0;
  endtask

  // Counts busy cycles until busy drops, bounded so a stuck DUT cannot hang.
  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int n;
    issue(3'b000, 32'hFFFFFFFF, 32'd2);
    busy_len(n);
    total++; if (n !== 5) begin bad++; $display("FAIL mult_busy_len got=%0d want=5", n); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
    total++; if (lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL mult_lo got=%h want=fffffffe", lo); end
    issue(3'b001, 32'hFFFFFFFF, 32'd2);
    busy_len(n);
    total++; if (n !== 5) begin bad++; $display("FAIL multu_busy_len got=%0d want=5", n); end
    total++; if (hi !== 32'h1) begin bad++; $display("FAIL multu_hi got=%h want=1", hi); end
    total++; if (lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_lo got=%h want=fffffffe", lo); end
  endtask

  task automatic test_div();
    int n;
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    busy_len(n);
    total++; if (n !== 10) begin bad++; $display("FAIL div_busy_len got=%0d want=10", n); end
    total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", lo); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", hi); end
    issue(3'b011, 32'd7, 32'd2);
    busy_len(n);
    total++; if (lo !== 32'd3) begin bad++; $display("FAIL divu_lo got=%h want=3", lo); end
    total++; if (hi !== 32'd1) begin bad++; $display("FAIL divu_hi got=%h want=1", hi); end
  endtask

  task automatic test_div_corners();
    int n;
    issue(3'b100, 32'h11, 32'd0);
    issue(3'b101, 32'h22, 32'd0);
    issue(3'b010, 32'd1234, 32'd0);
    busy_len(n);
    total++; if (n !== 10) begin bad++; $display("FAIL divzero_busy_len got=%0d want=10", n); end
    total++; if (hi !== 32'h11) begin bad++; $display("FAIL divzero_hi got=%h want=11", hi); end
    total++; if (lo !== 32'h22) begin bad++; $display("FAIL divzero_lo got=%h want=22", lo); end
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    busy_len(n);
    total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL divovf_lo got=%h want=80000000", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL divovf_hi got=%h want=0", hi); end
  endtask

  task automatic test_stall();
    int n;
    md_use = 1'b1; start = 1'b1; op = 3'b000; rs_val = 32'd6; rt_val = 32'd7;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_issue got=%0b want=1", stall); end
    tick();
    start = 1'b0; rs_val = 32'd0; rt_val = 32'd0;
    md_use = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_add got=%0b want=0", stall); end
    tick();
    md_use = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (stall === 1'b1) n++;
      tick();
    end
    total++; if (n !== 4) begin bad++; $display("FAIL stall_mflo_cycles got=%0d want=4", n); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_release got=%0b want=0", stall); end
    total++; if (lo !== 32'd42) begin bad++; $display("FAIL stall_mflo_lo got=%h want=2a", lo); end
    md_use = 1'b0;
  endtask

  task automatic test_reset_midop();
    issue(3'b011, 32'd100, 32'd3);
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b want=0", busy); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL midrst_hilo got=%h/%h want=0/0", hi, lo); end
    #1;
    reset = 1'b0;
    issue(3'b001, 32'd9, 32'd9);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_accept got=%0b want=1", busy); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (lo !== 32'd81) begin bad++; $display("FAIL midrst_result got=%h want=51", lo); end
  endtask

  task automatic test_ignored_start();
    int n;
    issue(3'b011, 32'd7, 32'd2);
    tick();
    issue(3'b000, 32'd5, 32'd5);
    busy_len(n);
    total++; if (n !== 8) begin bad++; $display("FAIL ign_remaining got=%0d want=8", n); end
    total++; if (lo !== 32'd3 || hi !== 32'd1) begin bad++; $display("FAIL ign_result got=%h/%h want=1/3", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'b100, 32'hDEADBEEF, 32'd0);
    total++; if (hi !== 32'hDEADBEEF) begin bad++; $display("FAIL mthi_hi got=%h want=deadbeef", hi); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%0b want=0", busy); end
    issue(3'b101, 32'h1234, 32'd0);
    total++; if (lo !== 32'h1234) begin bad++; $display("FAIL mtlo_lo got=%h want=1234", lo); end
    issue(3'b000, 32'd3, 32'd4);
    busy_len(n);
    total++; if (n !== 5) begin bad++; $display("FAIL b2b_busy_len got=%0d want=5", n); end
    total++; if (lo !== 32'd12 || hi !== 32'd0) begin bad++; $display("FAIL b2b_result got=%h/%h want=0/c", hi, lo); end
    issue(3'b110, 32'h5555, 32'd0);
    total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd12) begin bad++; $display("FAIL reserved_op got=%0b %h/%h want=0 0/c", busy, hi, lo); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000;
    rs_val = 32'd0; rt_val = 32'd0; md_use = 1'b0;
    #12;
    test_reset();
    test_mult();
    test_div();
    test_div_corners();
    test_stall();
    test_reset_midop();
    test_ignored_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The parameter MUL_CYCLES SHALL default to 5 and set the busy-cycle count for mult and multu.
REQ-002 The parameter DIV_CYCLES SHALL default to 10 and set the busy-cycle count for div and divu.
REQ-003 The port clk SHALL be a 1-bit input and the single clock; all state updates on its rising edge.
REQ-004 The port reset SHALL be a 1-bit input, asynchronous and active-high.
REQ-005 The port start SHALL be a 1-bit input; high for one cycle when the E-stage instruction is an MDU operation.
REQ-006 The port op SHALL be a 3-bit input: 000 mult, 001 multu, 010 div, 011divu, 100 mthi, 101 mtlo; 110 and 111 are reserved.
REQ-007 The ports rs_val and rt_val SHALL be 32-bit inputs carrying the forwarded E-stage operands.
REQ-008 The port md_use SHALL be a 1-bit input; high when the E-stage instruction is mult, multu, div, divu, mthi, mtlo, mfhi or mflo.
REQ-009 The port busy SHALL be a 1-bit output; high while a mult or div operation is in progress.
REQ-010 The port stall SHALL be a 1-bit output; the pipeline freezes D-stage and earlier stages and bubbles the E-stage while it is high.
REQ-011 The ports hi and lo SHALL be 32-bit outputs presenting the architectural HI and LO registers, read by mfhi and mflo.

Function
REQ-012 The state machine SHALL have three states: IDLE, MUL and DIV, held in a registered state plus a 4-bit down-counter cnt.
REQ-013 In IDLE with start=1, op=mult or multu SHALL move to MUL with cnt=MUL_CYCLES-1 and latch the operands and signedness.
REQ-014 In IDLE with start=1, op=div or divu SHALL move to DIV with cnt=DIV_CYCLES-1 and latch the operands and signedness.
REQ-015 In MUL or DIV, cnt SHALL decrement each cycle; at cnt=0 the next edge SHALL write HI and LO and return to IDLE.
REQ-016 The busy output SHALL be registered: high for exactly MUL_CYCLES or DIV_CYCLES cycles after the start edge, and low in the same cycle HI/LO show the result.
REQ-017 For mult, {hi,lo} SHALL be the signed 64-bit product; for multu, the unsigned 64-bit product.
REQ-018 For div and divu, lo SHALL be the quotient truncated toward zero and hi the remainder, whose sign follows the dividend (rs_val / rt_val).
REQ-019 For signed div of 0x80000000 by 0xFFFFFFFF, the result SHALL be lo=0x80000000 and hi=0.
REQ-020 On divide-by-zero (rt_val=0), the operation SHALL still run DIV_CYCLES busy cycles and SHALL leave HI and LO unchanged.
REQ-021 In IDLE with start=1, mthi SHALL load HI from rs_val and mtlo SHALL load LO from rs_val at the next edge, with no busy cycles.
REQ-022 The start input SHALL be ignored when busy=1 or op is reserved; no state change occurs.
REQ-023 The stall output SHALL be combinational, equal to md_use & (busy | (start & op in {mult, multu, div, divu})).
REQ-024 mfhi and mflo issued while busy SHALL stall until busy falls, then read the new result.

Reset
REQ-025 While reset=1, the block SHALL hold state=IDLE, cnt=0, busy=0, hi=0 and lo=0, independent of clk.
REQ-026 A reset asserted mid-operation SHALL discard the in-flight result; after release the block SHALL be IDLE and SHALL accept start on the first edge.

Verification
REQ-027 Mult timing: mult with rs=0xFFFFFFFF, rt=2 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=1, lo=0xFFFFFFFE.
REQ-028 Div signs: div with rs=-7, rt=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu with rs=7, rt=2 -> lo=3, hi=1.
REQ-029 Corner cases: divide-by-zero with prior hi=0x11, lo=0x22 -> 10 busy cycles, then hi and lo unchanged; 0x80000000 div -1 -> lo=0x80000000, hi=0.
REQ-030 Stall: mflo issued one cycle after a mult -> stall=1 for the remaining 4 cycles, and mflo reads the product; an add with md_use=0 during busy -> stall=0.
REQ-031 Mid-op reset and ignored start: reset at the 3rd busy cycle of div -> hi=lo=0, busy=0; start=1 with op=mult while busy -> ignored, and the original result completes on schedule.
REQ-032 mthi/mtlo: mthi with rs=0xDEADBEEF -> hi=0xDEADBEEF after 1 edge, busy stays 0; back-to-back mtlo then mult -> mult result overwrites lo.
